// File: rtl/svm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svm_sched_pkg
// Description : Shared types, widths and default sizing for the batch
//               scheduler and its slot allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package svm_sched_pkg;

    localparam int ID_W               = 4;
    localparam int CNT_W              = 3;
    localparam int STAT_W             = 32;
    localparam int DEF_MAX_BATCHES    = 16;
    localparam int DEF_BATCH_SIZE     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_ALLOC    = 3'd2,
        ST_REGISTER = 3'd3,
        ST_DISPATCH = 3'd4
    } sched_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/batch_slot_alloc.sv
`default_nettype none
// ============================================================================
// Module      : batch_slot_alloc
// Description : Priority encoder returning the lowest-index free batch slot.
// Revision    : 1.0 - initial release
// ============================================================================
module batch_slot_alloc
    import svm_sched_pkg::*;
#(
    parameter int MAX_BATCHES = DEF_MAX_BATCHES
)(
    input  logic [MAX_BATCHES-1:0] busy,
    output logic [ID_W-1:0]        free_id,
    output logic                   any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_id  = '0;
        any_free = 1'b0;
        for (int i = MAX_BATCHES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_id  = ID_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/batch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : batch_scheduler
// Description : Groups non-conflicting transactions into batches, allocates a
//               batch slot, registers it with the conflict manager and hands
//               it to the executor; tracks completions and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module batch_scheduler
    import svm_sched_pkg::*;
#(
    parameter int MAX_DEPENDENCIES = 1024,
    parameter int MAX_BATCHES      = DEF_MAX_BATCHES,
    parameter int BATCH_SIZE       = DEF_BATCH_SIZE,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAX_DEPENDENCIES-1:0] in_read_deps,
    input  logic [MAX_DEPENDENCIES-1:0] in_write_deps,
    input  logic [63:0]                 in_owner_id,
    output logic                        cm_txn_valid,
    output logic [MAX_DEPENDENCIES-1:0] cm_txn_read_deps,
    output logic [MAX_DEPENDENCIES-1:0] cm_txn_write_deps,
    output logic [63:0]                 cm_txn_owner_id,
    input  logic                        cm_has_conflict,
    output logic                        cm_new_batch_valid,
    output logic [ID_W-1:0]             cm_new_batch_id,
    output logic [MAX_DEPENDENCIES-1:0] cm_new_batch_read_deps,
    output logic [MAX_DEPENDENCIES-1:0] cm_new_batch_write_deps,
    output logic [63:0]                 cm_new_batch_owner_id,
    output logic                        cm_batch_completed,
    output logic [ID_W-1:0]             cm_batch_id,
    output logic                        exec_valid,
    input  logic                        exec_ready,
    output logic [ID_W-1:0]             exec_batch_id,
    output logic [CNT_W-1:0]            exec_txn_count,
    input  logic                        done_valid,
    input  logic [ID_W-1:0]             done_batch_id,
    output logic [MAX_BATCHES-1:0]      slot_busy,
    output logic [STAT_W-1:0]           batches_issued,
    output logic [STAT_W-1:0]           cm_stall_cycles,
    output logic [STAT_W-1:0]           bad_done_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] C_TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BATCH_SIZE = CNT_W'(BATCH_SIZE);

    sched_state_t                r_state;
    sched_state_t                w_next;
    logic [MAX_DEPENDENCIES-1:0] r_rd_acc;
    logic [MAX_DEPENDENCIES-1:0] r_wr_acc;
    logic [63:0]                 r_owner;
    logic [CNT_W-1:0]            r_count;
    logic [TMR_W-1:0]            r_timer;
    logic [ID_W-1:0]             r_batch_id;
    logic [MAX_BATCHES-1:0]      r_slot_busy;
    logic                        r_cmp_valid;
    logic [ID_W-1:0]             r_cmp_id;
    logic [STAT_W-1:0]           r_issued;
    logic [STAT_W-1:0]           r_stalls;
    logic [STAT_W-1:0]           r_bad;

    logic                        w_local_conflict;
    logic                        w_can_take;
    logic                        w_accept;
    logic                        w_stall;
    logic                        w_alloc;
    logic                        w_register;
    logic                        w_retire;
    logic                        w_timer_tick;
    logic [CNT_W-1:0]            w_count_inc;
    logic [ID_W-1:0]             w_free_id;
    logic                        w_any_free;
    logic [MAX_BATCHES-1:0]      w_done_mask;
    logic [MAX_BATCHES-1:0]      w_reg_mask;
    logic                        w_done_hit;

    // RAW, WAW and WAR overlap against the batch being accumulated.
    assign w_local_conflict = |((in_read_deps  & r_wr_acc) |
                                (in_write_deps & r_wr_acc) |
                                (in_write_deps & r_rd_acc));
    assign w_count_inc      = r_count + 1'b1;

    batch_slot_alloc #(
        .MAX_BATCHES (MAX_BATCHES)
    ) u_slot_alloc (
        .busy     (r_slot_busy),
        .free_id  (w_free_id),
        .any_free (w_any_free)
    );

    // One-hot slot masks for the completion being retired and the batch being registered.
    for (genvar gi = 0; gi < MAX_BATCHES; gi++) begin : g_slot_masks
        assign w_done_mask[gi] = done_valid && (done_batch_id == ID_W'(gi));
        assign w_reg_mask[gi]  = w_register && (r_batch_id == ID_W'(gi));
    end

    assign w_done_hit = |(w_done_mask & r_slot_busy);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode, handshake outputs and datapath strobes.
    always_comb begin
        w_next       = r_state;
        w_can_take   = 1'b0;
        cm_txn_valid = 1'b0;
        cm_new_batch_valid = 1'b0;
        exec_valid   = 1'b0;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        w_alloc      = 1'b0;
        w_register   = 1'b0;
        w_retire     = 1'b0;
        w_timer_tick = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                cm_txn_valid = in_valid;
                w_can_take   = !cm_has_conflict && !w_local_conflict &&
                               (r_count < C_BATCH_SIZE);
                w_accept     = in_valid && w_can_take;
                w_stall      = in_valid && cm_has_conflict;
                if (w_accept) begin
                    w_next = (w_count_inc == C_BATCH_SIZE) ? ST_ALLOC : ST_ACCUM;
                end else if (r_state == ST_ACCUM) begin
                    // A conflicting transaction closes the batch and is retried later.
                    if (in_valid && w_local_conflict && (r_count != '0))
                        w_next = ST_ALLOC;
                    else if (r_timer == C_TMR_LAST)
                        w_next = ST_ALLOC;
                    else
                        w_timer_tick = 1'b1;
                end
            end
            ST_ALLOC: begin
                if (w_any_free) begin
                    w_alloc = 1'b1;
                    w_next  = ST_REGISTER;
                end
            end
            ST_REGISTER: begin
                cm_new_batch_valid = 1'b1;
                w_register         = 1'b1;
                w_next             = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                exec_valid = 1'b1;
                if (exec_ready) begin
                    w_retire = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Batch accumulator, transaction count, idle timer and allocated ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_acc   <= '0;
            r_wr_acc   <= '0;
            r_owner    <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_batch_id <= '0;
        end else begin
            if (w_accept) begin
                r_rd_acc <= r_rd_acc | in_read_deps;
                r_wr_acc <= r_wr_acc | in_write_deps;
                r_count  <= w_count_inc;
                r_timer  <= '0;
                if (r_count == '0)
                    r_owner <= in_owner_id;
            end else if (w_timer_tick) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_alloc)
                r_batch_id <= w_free_id;
            if (w_retire) begin
                r_rd_acc <= '0;
                r_wr_acc <= '0;
                r_count  <= '0;
                r_timer  <= '0;
            end
        end
    end

    // Slot occupancy and completion pulse; a retire and a register in the same cycle both apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_busy <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_id    <= '0;
        end else begin
            r_slot_busy <= (r_slot_busy & ~w_done_mask) | w_reg_mask;
            r_cmp_valid <= w_done_hit;
            if (w_done_hit)
                r_cmp_id <= done_batch_id;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued <= '0;
            r_stalls <= '0;
            r_bad    <= '0;
        end else begin
            if (w_retire)
                r_issued <= sat_inc(r_issued);
            if (w_stall)
                r_stalls <= sat_inc(r_stalls);
            if (done_valid && !w_done_hit)
                r_bad <= sat_inc(r_bad);
        end
    end

    assign in_ready                = w_can_take;
    assign cm_txn_read_deps        = in_read_deps;
    assign cm_txn_write_deps       = in_write_deps;
    assign cm_txn_owner_id         = in_owner_id;
    assign cm_new_batch_id         = r_batch_id;
    assign cm_new_batch_read_deps  = r_rd_acc;
    assign cm_new_batch_write_deps = r_wr_acc;
    assign cm_new_batch_owner_id   = r_owner;
    assign cm_batch_completed      = r_cmp_valid;
    assign cm_batch_id             = r_cmp_id;
    assign exec_batch_id           = r_batch_id;
    assign exec_txn_count          = r_count;
    assign slot_busy               = r_slot_busy;
    assign batches_issued          = r_issued;
    assign cm_stall_cycles         = r_stalls;
    assign bad_done_count          = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_batch_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_batch_scheduler
// Description : Bench for batch_scheduler: directed scenarios plus random
//               traffic compared each cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_batch_scheduler;

    localparam int DW = 64;
    localparam int NB = 16;
    localparam int BS = 4;
    localparam int TO = 64;
    localparam int P_COLLECT  = 0;
    localparam int P_FIND     = 1;
    localparam int P_ANNOUNCE = 2;
    localparam int P_HAND     = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_rd, in_wr;
    logic [63:0]   in_owner;
    logic          cm_txn_valid;
    logic [DW-1:0] cm_txn_rd, cm_txn_wr;
    logic [63:0]   cm_txn_owner;
    logic          cmc;
    logic          nb_valid;
    logic [3:0]    nb_id;
    logic [DW-1:0] nb_rd, nb_wr;
    logic [63:0]   nb_owner;
    logic          cmp_valid;
    logic [3:0]    cmp_id;
    logic          exec_valid, exec_ready;
    logic [3:0]    exec_id;
    logic [2:0]    exec_cnt;
    logic          done_valid;
    logic [3:0]    done_id;
    logic [NB-1:0] slot_busy;
    logic [31:0]   issued, stalls, bad;

    always #5 clk = ~clk;

    batch_scheduler #(.MAX_DEPENDENCIES(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_read_deps(in_rd), .in_write_deps(in_wr), .in_owner_id(in_owner),
        .cm_txn_valid(cm_txn_valid), .cm_txn_read_deps(cm_txn_rd),
        .cm_txn_write_deps(cm_txn_wr), .cm_txn_owner_id(cm_txn_owner),
        .cm_has_conflict(cmc),
        .cm_new_batch_valid(nb_valid), .cm_new_batch_id(nb_id),
        .cm_new_batch_read_deps(nb_rd), .cm_new_batch_write_deps(nb_wr),
        .cm_new_batch_owner_id(nb_owner),
        .cm_batch_completed(cmp_valid), .cm_batch_id(cmp_id),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_batch_id(exec_id), .exec_txn_count(exec_cnt),
        .done_valid(done_valid), .done_batch_id(done_id),
        .slot_busy(slot_busy), .batches_issued(issued),
        .cm_stall_cycles(stalls), .bad_done_count(bad)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_phase, m_cnt, m_idle, m_slot, m_cmp_id;
    logic [DW-1:0] m_rd, m_wr;
    logic [63:0]   m_owner;
    logic [NB-1:0] m_busy;
    bit            m_cmp;
    int            m_issued, m_stalls, m_bad;
    int            q_pend[$];

    task automatic model_reset();
        m_phase = P_COLLECT; m_cnt = 0; m_idle = 0; m_slot = 0; m_cmp_id = 0;
        m_rd = '0; m_wr = '0; m_owner = '0; m_busy = '0; m_cmp = 0;
        m_issued = 0; m_stalls = 0; m_bad = 0;
        q_pend.delete();
    endtask

    function automatic bit overlaps();
        return ((in_rd & m_wr) | (in_wr & m_wr) | (in_wr & m_rd)) != '0;
    endfunction

    task automatic compare_outputs();
        bit collect;
        collect = (m_phase == P_COLLECT);
        chk("in_ready", in_ready, collect && !cmc && !overlaps() && (m_cnt < BS));
        chk("cm_txn_valid", cm_txn_valid, collect && in_valid);
        chk("cm_txn_rd", cm_txn_rd, in_rd);
        chk("cm_txn_wr", cm_txn_wr, in_wr);
        chk("cm_txn_owner", cm_txn_owner, in_owner);
        chk("new_batch_valid", nb_valid, m_phase == P_ANNOUNCE);
        if (m_phase == P_ANNOUNCE) begin
            chk("new_batch_id", nb_id, m_slot);
            chk("new_batch_rd", nb_rd, m_rd);
            chk("new_batch_wr", nb_wr, m_wr);
            chk("new_batch_owner", nb_owner, m_owner);
        end
        chk("exec_valid", exec_valid, m_phase == P_HAND);
        if (m_phase == P_HAND) begin
            chk("exec_batch_id", exec_id, m_slot);
            chk("exec_txn_count", exec_cnt, m_cnt);
        end
        chk("slot_busy", slot_busy, m_busy);
        chk("batch_completed", cmp_valid, m_cmp);
        if (m_cmp) chk("completed_id", cmp_id, m_cmp_id);
        chk("batches_issued", issued, m_issued);
        chk("cm_stall_cycles", stalls, m_stalls);
        chk("bad_done_count", bad, m_bad);
    endtask

    task automatic model_advance();
        bit            hit, collect, take;
        logic [NB-1:0] nbusy;
        int            f;
        hit     = done_valid && m_busy[done_id];
        nbusy   = m_busy;
        collect = (m_phase == P_COLLECT);
        take    = collect && in_valid && !cmc && !overlaps() && (m_cnt < BS);
        if (collect && in_valid && cmc) m_stalls++;
        if (done_valid && !hit) m_bad++;
        if (hit) begin
            nbusy[done_id] = 1'b0;
            m_cmp_id = int'(done_id);
        end
        m_cmp = hit;
        case (m_phase)
            P_COLLECT: begin
                if (take) begin
                    if (m_cnt == 0) m_owner = in_owner;
                    m_rd |= in_rd;
                    m_wr |= in_wr;
                    m_cnt++;
                    m_idle = 0;
                    if (m_cnt == BS) m_phase = P_FIND;
                end else if (m_cnt > 0) begin
                    if (in_valid && overlaps()) m_phase = P_FIND;
                    else if (m_idle == TO - 1)  m_phase = P_FIND;
                    else                        m_idle++;
                end
            end
            P_FIND: begin
                f = -1;
                for (int i = 0; i < NB; i++)
                    if (f < 0 && !m_busy[i]) f = i;
                if (f >= 0) begin
                    m_slot  = f;
                    m_phase = P_ANNOUNCE;
                end
            end
            P_ANNOUNCE: begin
                nbusy[m_slot] = 1'b1;
                m_phase = P_HAND;
            end
            default: begin
                if (exec_ready) begin
                    q_pend.push_back(m_slot);
                    m_rd = '0; m_wr = '0; m_cnt = 0; m_idle = 0;
                    m_issued++;
                    m_phase = P_COLLECT;
                end
            end
        endcase
        m_busy = nbusy;
    endtask

    // One clock: check outputs for the current inputs, then advance the model at the edge.
    task automatic step();
        #1;
        compare_outputs();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        in_valid = 0; in_rd = '0; in_wr = '0; in_owner = '0;
        cmc = 0; exec_ready = 0; done_valid = 0; done_id = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic send(input logic [DW-1:0] rd, input logic [DW-1:0] wr, input logic [63:0] own);
        in_valid = 1; in_rd = rd; in_wr = wr; in_owner = own;
        step();
        in_valid = 0; in_rd = '0; in_wr = '0;
    endtask

    task automatic dispatch_now();
        exec_ready = 1;
        step();
        exec_ready = 0;
    endtask

    initial begin
        int k;
        int idx;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset state
        #1;
        chk("rst_slot_busy", slot_busy, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_issued", issued, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_completed", cmp_valid, 0);

        // Four disjoint writers form one full batch
        for (int i = 0; i < 4; i++) send('0, DW'(1) << i, 64'hA0 + 64'(i));
        step();
        #1;
        chk("full_new_valid", nb_valid, 1);
        chk("full_new_id", nb_id, 0);
        chk("full_new_wr", nb_wr, 64'hF);
        chk("full_new_owner", nb_owner, 64'hA0);
        step();
        #1;
        chk("full_exec_count", exec_cnt, 4);
        dispatch_now();
        chk("full_issued", issued, 1);

        // RAW on bit 5 closes the batch; the reader lands in the next one, which then times out
        do_reset();
        in_valid = 1; in_wr = DW'(1) << 5; in_owner = 64'd1;
        step();
        in_wr = '0; in_rd = DW'(1) << 5; in_owner = 64'd2;
        #1;
        chk("raw_blocked", in_ready, 0);
        step();
        step();
        #1;
        chk("raw_new_id", nb_id, 0);
        chk("raw_new_wr", nb_wr, 64'h20);
        step();
        #1;
        chk("raw_exec_count", exec_cnt, 1);
        dispatch_now();
        #1;
        chk("raw_retry_ready", in_ready, 1);
        step();
        in_valid = 0; in_rd = '0;
        k = 0;
        while (m_phase == P_COLLECT && k < 200) begin
            step();
            k++;
        end
        chk("timeout_cycles", k, 64);
        step();
        #1;
        chk("timeout_new_id", nb_id, 1);
        chk("timeout_new_owner", nb_owner, 64'd2);
        step();
        #1;
        chk("timeout_exec_count", exec_cnt, 1);
        dispatch_now();
        done_valid = 1; done_id = 4'd1;
        step();
        done_valid = 0;
        #1;
        chk("done_pulse", cmp_valid, 1);
        chk("done_id", cmp_id, 1);
        chk("done_busy", slot_busy, 16'h0001);

        // Conflict-manager stall for ten cycles
        do_reset();
        in_valid = 1; in_wr = DW'(1) << 9; cmc = 1;
        repeat (10) begin
            #1;
            chk("stall_ready_low", in_ready, 0);
            step();
        end
        chk("stall_cycles", stalls, 10);
        cmc = 0;
        #1;
        chk("stall_released", in_ready, 1);
        step();
        in_wr = '0; in_rd = DW'(1) << 9;
        #1;
        chk("stall_accepted", in_ready, 0);
        drive_idle();

        // Fill every slot, then a 17th batch waits for slot 7 to retire
        do_reset();
        for (int b = 0; b < 16; b++) begin
            for (int t = 0; t < 4; t++) send('0, '0, 64'(b));
            step();
            #1;
            chk("fill_new_id", nb_id, b);
            step();
            dispatch_now();
        end
        chk("fill_all_busy", slot_busy, 16'hFFFF);
        for (int t = 0; t < 4; t++) send('0, '0, 64'd99);
        repeat (5) begin
            step();
            #1;
            chk("alloc_hold", nb_valid, 0);
        end
        done_valid = 1; done_id = 4'd7;
        step();
        done_valid = 0;
        #1;
        chk("slot7_pulse", cmp_valid, 1);
        chk("slot7_id", cmp_id, 7);
        step();
        #1;
        chk("slot7_reused_valid", nb_valid, 1);
        chk("slot7_reused_id", nb_id, 7);

        // Spurious completion, then reset while a batch waits for dispatch
        do_reset();
        done_valid = 1; done_id = 4'd3;
        step();
        done_valid = 0;
        #1;
        chk("bad_done", bad, 1);
        chk("bad_no_pulse", cmp_valid, 0);
        for (int t = 0; t < 4; t++) send('0, DW'(1) << t, 64'd5);
        step();
        step();
        #1;
        chk("pre_reset_exec", exec_valid, 1);
        rst_n = 0;
        #1;
        chk("arst_exec_valid", exec_valid, 0);
        chk("arst_slot_busy", slot_busy, 0);
        chk("arst_bad", bad, 0);
        chk("arst_issued", issued, 0);
        chk("arst_new_valid", nb_valid, 0);
        chk("arst_completed", cmp_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Random traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_rd      = ($urandom_range(0, 1) == 1) ? (DW'(1) << $urandom_range(0, 23)) : '0;
            in_wr      = ($urandom_range(0, 1) == 1) ? (DW'(1) << $urandom_range(0, 23)) : '0;
            in_owner   = {$urandom, $urandom};
            cmc        = ($urandom_range(0, 9) == 0);
            exec_ready = ($urandom_range(0, 1) == 1);
            done_valid = 0;
            if (q_pend.size() > 0 && $urandom_range(0, 3) == 0) begin
                idx        = $urandom_range(0, q_pend.size() - 1);
                done_id    = 4'(q_pend[idx]);
                q_pend.delete(idx);
                done_valid = 1;
            end else if ($urandom_range(0, 49) == 0) begin
                done_id    = 4'($urandom_range(0, 15));
                done_valid = 1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/batch_scheduler.md
BATCH_SCHEDULER -- requirements
Module: batch_scheduler

Interface
REQ-001 Parameters SHALL be: MAX_DEPENDENCIES, default 1024, dependency vector width; MAX_BATCHES, default 16, number of batch slots (the ID width is 4 bits); BATCH_SIZE, default 4, transactions per batch; TIMEOUT_CYCLES, default 64, idle cycles before a partial batch closes.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid / in_ready, in / out, 1 each, transaction handshake.
- in_read_deps / in_write_deps, in, MAX_DEPENDENCIES each, transaction dependency vectors.
- in_owner_id, in, 64, transaction owner.
- cm_txn_valid, out, 1; cm_txn_read_deps / cm_txn_write_deps, out, MAX_DEPENDENCIES each; cm_txn_owner_id, out, 64. These form the conflict-manager probe.
- cm_has_conflict, in, 1, conflict-manager verdict on the probe.
- cm_new_batch_valid, out, 1; cm_new_batch_id, out, 4; cm_new_batch_read_deps / cm_new_batch_write_deps, out, MAX_DEPENDENCIES each; cm_new_batch_owner_id, out, 64. These register a batch with the conflict manager.
- cm_batch_completed, out, 1; cm_batch_id, out, 4. These retire a batch in the conflict manager.
- exec_valid / exec_ready, out / in, 1 each, dispatch handshake.
- exec_batch_id, out, 4; exec_txn_count, out, 3. Dispatched batch ID and its transaction count.
- done_valid, in, 1; done_batch_id, in, 4. Executor completion pulse.
- slot_busy, out, MAX_BATCHES, occupied-slot bitmap.
- batches_issued, out, 32; cm_stall_cycles, out, 32; bad_done_count, out, 32. Statistics counters.

Function
REQ-003 The FSM SHALL have the states IDLE, ACCUM, ALLOC, REGISTER and DISPATCH.
REQ-004 cm_txn_valid SHALL equal in_valid in IDLE and ACCUM and SHALL be 0 in every other state, with the cm_txn_* buses driven combinationally from the in_* buses.
REQ-005 The block SHALL raise a local conflict when the incoming transaction has any RAW, WAW or WAR overlap with the accumulated batch read/write vectors, using the same formulas as the conflict manager.
REQ-006 In IDLE or ACCUM, in_ready SHALL be 1 only when cm_has_conflict=0, there is no local conflict, and count<BATCH_SIZE.
REQ-007 On each accept, the block SHALL OR the transaction deps into the accumulator, increment count, reset the timer, and latch the owner of the first transaction as the batch owner; IDLE SHALL then move to ACCUM.
REQ-008 When in_valid=1 and cm_has_conflict=1, the block SHALL stall, incrementing cm_stall_cycles each cycle and leaving the accumulator unchanged.
REQ-009 A local conflict with count>0 SHALL close the batch (go to ALLOC) without accepting the transaction, which is retried in the next batch.
REQ-010 In ACCUM, the block SHALL go to ALLOC when count reaches BATCH_SIZE, or when the timer reaches TIMEOUT_CYCLES-1 with no accept that cycle.
REQ-011 ALLOC SHALL select the lowest-index free bit of slot_busy; if every slot is busy, it SHALL hold with in_ready=0.
REQ-012 REGISTER SHALL last exactly one cycle, pulse cm_new_batch_valid with the ID and accumulated deps, and set that bit of slot_busy at the closing edge.
REQ-013 DISPATCH SHALL hold exec_valid with a stable exec_batch_id and exec_txn_count until exec_ready=1, then clear the accumulator, increment batches_issued, and return to IDLE.
REQ-014 A done_valid arriving in any state SHALL produce cm_batch_completed and cm_batch_id one cycle later and clear the slot_busy bit at the same edge.
REQ-015 A done_valid for a slot that is not busy SHALL increment bad_done_count and generate no cm_batch_completed pulse.
REQ-016 A slot freed by a completion SHALL become allocatable on the following cycle.
REQ-017 Completion and REGISTER in the same cycle SHALL both take effect.
REQ-018 All counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, clear the accumulator, count, timer, slot_busy and all counters, and drive every valid/pulse output to 0.
REQ-020 Reset applied mid-operation SHALL discard in-flight batches with no completion pulses; the conflict manager is reset by the same rst_n.

Structure
REQ-021 The FSM state encoding and the defaults of MAX_BATCHES, BATCH_SIZE and TIMEOUT_CYCLES SHALL reside in the shared package svm_sched_pkg.
REQ-022 The free-slot priority encoder SHALL be implemented as the sub-module batch_slot_alloc, with input busy bitmap and outputs free_id and any_free.

Verification
REQ-023 Send four non-overlapping transactions (bits 0–3 written) -> one batch is issued with cm_new_batch_id=0, exec_txn_count=4, and batches_issued=1.
REQ-024 Send T1 writing bit 5, then T2 reading bit 5 -> the batch closes with count=1, and T2 opens batch ID 1.
REQ-025 Hold cm_has_conflict=1 for 10 cycles with in_valid=1 -> in_ready stays 0, cm_stall_cycles=10, and the transaction is accepted on the first clear cycle.
REQ-026 Fill all 16 slots, then close a 17th batch -> ALLOC holds; done_valid for slot 7 -> cm_batch_completed is pulsed with ID 7 and the next batch receives ID 7.
REQ-027 Send one transaction and then idle -> the batch closes after 64 cycles with exec_txn_count=1.
REQ-028 Apply done_valid for a free slot 3, then assert rst_n low during DISPATCH -> bad_done_count=1, and all outputs return to their reset values immediately.
